// File: rtl/lap_gate.sv
// Laser lap gate: synchronizes and debounces the beam detector, then runs an
// IDLE/RUN/LOCK session FSM that starts the timer, counts laps and keeps the best time.

module lap_gate #(
    parameter int unsigned DEB_CYCLES     = 16,
    parameter int unsigned LOCKOUT_CYCLES = 4900000,
    parameter int unsigned LOCK_BIT       = 23
) (
    input  logic       master_clk,
    input  logic       rs_n,
    input  logic       laser_detector,
    input  logic       stop,
    input  logic       clear,
    input  logic [6:0] seconds,
    input  logic [6:0] milliseconds,
    output logic       timer_en,
    output logic       lap_rs,
    output logic       lap_pulse,
    output logic [6:0] lap_count,
    output logic [6:0] last_sec,
    output logic [6:0] last_ms,
    output logic [6:0] best_sec,
    output logic [6:0] best_ms,
    output logic       best_valid
);

    localparam int unsigned         DebW     = $clog2(DEB_CYCLES + 1);
    localparam logic [DebW-1:0]     DebLast  = DebW'(DEB_CYCLES - 1);
    localparam logic [LOCK_BIT-1:0] LockLoad = LOCK_BIT'(LOCKOUT_CYCLES - 1);
    localparam logic [6:0]          MaxLaps  = 7'd99;

    typedef enum logic [1:0] {StIdle, StRun, StLock} state_e;

    // Reset: asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge master_clk or negedge rs_n) begin
        if (!rs_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // Detector synchronizer and debounce filter
    logic [1:0]      det_sync_q;
    logic            det_s;
    logic            filt_q, filt_d;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic            brk;

    assign det_s = det_sync_q[1];

    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        brk       = 1'b0;
        if (det_s != filt_q) begin
            if (deb_cnt_q == DebLast) begin
                filt_d = det_s;
                // A change away from a filtered 1 is a falling edge: beam broken.
                brk    = filt_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge master_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            det_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            deb_cnt_q  <= '0;
        end else begin
            det_sync_q <= {det_sync_q[0], laser_detector};
            filt_q     <= filt_d;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    // Session FSM and result registers
    state_e              state_q, state_d;
    logic [LOCK_BIT-1:0] lock_cnt_q, lock_cnt_d;
    logic                timer_en_q, timer_en_d;
    logic                lap_rs_q, lap_rs_d;
    logic                lap_pulse_q, lap_pulse_d;
    logic [6:0]          lap_count_q, lap_count_d;
    logic [6:0]          last_sec_q, last_sec_d;
    logic [6:0]          last_ms_q, last_ms_d;
    logic [6:0]          best_sec_q, best_sec_d;
    logic [6:0]          best_ms_q, best_ms_d;
    logic                best_valid_q, best_valid_d;
    logic                faster;

    assign faster = {seconds, milliseconds} < {best_sec_q, best_ms_q};

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        lap_rs_d     = 1'b0;
        lap_pulse_d  = 1'b0;
        lap_count_d  = lap_count_q;
        last_sec_d   = last_sec_q;
        last_ms_d    = last_ms_q;
        best_sec_d   = best_sec_q;
        best_ms_d    = best_ms_q;
        best_valid_d = best_valid_q;

        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    lap_count_d  = '0;
                    last_sec_d   = '0;
                    last_ms_d    = '0;
                    best_sec_d   = '0;
                    best_ms_d    = '0;
                    best_valid_d = 1'b0;
                end
                if (brk) begin
                    state_d    = StLock;
                    lock_cnt_d = LockLoad;
                    lap_rs_d   = 1'b1;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (brk) begin
                    state_d     = StLock;
                    lock_cnt_d  = LockLoad;
                    lap_rs_d    = 1'b1;
                    lap_pulse_d = 1'b1;
                    last_sec_d  = seconds;
                    last_ms_d   = milliseconds;
                    if (lap_count_q != MaxLaps) begin
                        lap_count_d = lap_count_q + 7'd1;
                    end
                    // Ties keep the earlier best lap.
                    if (!best_valid_q || faster) begin
                        best_sec_d   = seconds;
                        best_ms_d    = milliseconds;
                        best_valid_d = 1'b1;
                    end
                end
            end
            StLock: begin
                if (stop) begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                lock_cnt_d = '0;
            end
        endcase

        timer_en_d = (state_d != StIdle);
    end

    always_ff @(posedge master_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q      <= StIdle;
            lock_cnt_q   <= '0;
            timer_en_q   <= 1'b0;
            lap_rs_q     <= 1'b0;
            lap_pulse_q  <= 1'b0;
            lap_count_q  <= '0;
            last_sec_q   <= '0;
            last_ms_q    <= '0;
            best_sec_q   <= '0;
            best_ms_q    <= '0;
            best_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            timer_en_q   <= timer_en_d;
            lap_rs_q     <= lap_rs_d;
            lap_pulse_q  <= lap_pulse_d;
            lap_count_q  <= lap_count_d;
            last_sec_q   <= last_sec_d;
            last_ms_q    <= last_ms_d;
            best_sec_q   <= best_sec_d;
            best_ms_q    <= best_ms_d;
            best_valid_q <= best_valid_d;
        end
    end

    assign timer_en   = timer_en_q;
    assign lap_rs     = lap_rs_q;
    assign lap_pulse  = lap_pulse_q;
    assign lap_count  = lap_count_q;
    assign last_sec   = last_sec_q;
    assign last_ms    = last_ms_q;
    assign best_sec   = best_sec_q;
    assign best_ms    = best_ms_q;
    assign best_valid = best_valid_q;

`ifndef SYNTHESIS
    a_rs_single: assert property (@(posedge master_clk) disable iff (!rst_n_int)
        !(lap_rs_q && $past(lap_rs_q)));
    a_pulse_rs: assert property (@(posedge master_clk) disable iff (!rst_n_int)
        lap_pulse_q |-> lap_rs_q);
    a_count_max: assert property (@(posedge master_clk) disable iff (!rst_n_int)
        lap_count_q <= MaxLaps);
`endif

endmodule

// File: tb/tb_lap_gate.sv
// Randomized scoreboard bench for lap_gate: a lap-level model predicts sessions,
// laps and best times; a negedge monitor checks each lap_pulse against the queue.

module tb_lap_gate;

    localparam int unsigned Deb  = 4;
    localparam int unsigned Lock = 20;
    // Edges from driving the detector low to the edge on which the FSM sees the break:
    // two synchronizer stages plus Deb filter cycles.
    localparam int BrkLat = 2 + Deb;

    logic       master_clk = 1'b0;
    logic       rs_n = 1'b0;
    logic       laser_detector = 1'b1;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] seconds = '0;
    logic [6:0] milliseconds = '0;
    logic       timer_en, lap_rs, lap_pulse, best_valid;
    logic [6:0] lap_count, last_sec, last_ms, best_sec, best_ms;

    lap_gate #(
        .DEB_CYCLES    (Deb),
        .LOCKOUT_CYCLES(Lock),
        .LOCK_BIT      (5)
    ) dut (
        .master_clk    (master_clk),
        .rs_n          (rs_n),
        .laser_detector(laser_detector),
        .stop          (stop),
        .clear         (clear),
        .seconds       (seconds),
        .milliseconds  (milliseconds),
        .timer_en      (timer_en),
        .lap_rs        (lap_rs),
        .lap_pulse     (lap_pulse),
        .lap_count     (lap_count),
        .last_sec      (last_sec),
        .last_ms       (last_ms),
        .best_sec      (best_sec),
        .best_ms       (best_ms),
        .best_valid    (best_valid)
    );

    always #5 master_clk = ~master_clk;

    typedef struct {
        int cnt;
        int lsec;
        int lms;
        int bsec;
        int bms;
        int bvalid;
    } lap_t;

    lap_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rs_seen  = 0;
    int exp_rs   = 0;
    bit mon_en   = 0;

    // Model state: session active, edge of last accepted break, results.
    bit running = 0;
    int last_brk = 0;
    int m_cnt = 0, m_lsec = 0, m_lms = 0, m_bsec = 0, m_bms = 0, m_bvalid = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int edge_now();
        return int'($time / 10);
    endfunction

    task automatic zero_results();
        m_cnt = 0; m_lsec = 0; m_lms = 0; m_bsec = 0; m_bms = 0; m_bvalid = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".timer_en"}, int'(timer_en), int'(running));
        chk({tag, ".lap_count"}, int'(lap_count), m_cnt);
        chk({tag, ".last_sec"}, int'(last_sec), m_lsec);
        chk({tag, ".last_ms"}, int'(last_ms), m_lms);
        chk({tag, ".best_sec"}, int'(best_sec), m_bsec);
        chk({tag, ".best_ms"}, int'(best_ms), m_bms);
        chk({tag, ".best_valid"}, int'(best_valid), m_bvalid);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".timer_en"}, int'(timer_en), 0);
        chk({tag, ".lap_rs"}, int'(lap_rs), 0);
        chk({tag, ".lap_pulse"}, int'(lap_pulse), 0);
        chk({tag, ".lap_count"}, int'(lap_count), 0);
        chk({tag, ".last"}, int'({last_sec, last_ms}), 0);
        chk({tag, ".best"}, int'({best_sec, best_ms}), 0);
        chk({tag, ".best_valid"}, int'(best_valid), 0);
    endtask

    // Beam low for len cycles then high for gap cycles; stop/clear optionally
    // presented on exactly the edge where the break reaches the FSM.
    task automatic do_break(input int len, input int gap, input int sec, input int ms,
                            input bit with_stop, input bit with_clear);
        int   e0;
        int   brk_t;
        int   t;
        lap_t e;
        @(posedge master_clk);
        e0 = edge_now();
        brk_t = e0 + BrkLat;
        if (with_clear && !running) zero_results();
        if (with_stop && running) begin
            running = 0;
        end else if (len >= int'(Deb)) begin
            if (!running) begin
                running  = 1;
                last_brk = brk_t;
                exp_rs++;
            end else if (brk_t - last_brk > int'(Lock)) begin
                t = sec * 100 + ms;
                m_cnt  = (m_cnt < 99) ? m_cnt + 1 : 99;
                m_lsec = sec;
                m_lms  = ms;
                if (m_bvalid == 0 || t < m_bsec * 100 + m_bms) begin
                    m_bsec = sec; m_bms = ms; m_bvalid = 1;
                end
                e = '{m_cnt, m_lsec, m_lms, m_bsec, m_bms, m_bvalid};
                exp_q.push_back(e);
                exp_rs++;
                last_brk = brk_t;
            end
        end
        for (int i = 0; i < len + gap; i++) begin
            if (i > 0) @(posedge master_clk);
            #1;
            seconds        = 7'(sec);
            milliseconds   = 7'(ms);
            laser_detector = (i < len) ? 1'b0 : 1'b1;
            stop           = with_stop && (i == BrkLat - 1);
            clear          = with_clear && (i == BrkLat - 1);
        end
        @(posedge master_clk);
        #1;
        stop  = 1'b0;
        clear = 1'b0;
        check_state("brk");
    endtask

    task automatic pulse_ctl(input bit is_stop);
        @(posedge master_clk);
        #1;
        stop  = is_stop;
        clear = !is_stop;
        @(posedge master_clk);
        #1;
        stop  = 1'b0;
        clear = 1'b0;
        if (is_stop) running = 0;
        else if (!running) zero_results();
        repeat (2) @(posedge master_clk);
        #1;
        check_state(is_stop ? "stop" : "clear");
    endtask

    task automatic do_reset();
        @(posedge master_clk);
        #1;
        rs_n = 1'b0;
        #2;
        check_zero("rst_async");
        repeat (3) @(posedge master_clk);
        #1;
        rs_n = 1'b1;
        running = 0;
        zero_results();
        repeat (4) @(posedge master_clk);
        #1;
        check_zero("rst_after");
    endtask

    // Monitor: pops one expectation per lap_pulse and checks the published results.
    initial begin
        bit   prev_rs = 0;
        lap_t e;
        forever begin
            @(negedge master_clk);
            if (mon_en) begin
                if (lap_rs) rs_seen++;
                if (lap_rs && prev_rs) chk("lap_rs_repeat", int'(lap_rs && prev_rs), 0);
                if (lap_pulse) begin
                    chk("lap_rs_with_pulse", int'(lap_rs), 1);
                    if (exp_q.size() == 0) begin
                        chk("lap_pulse_expected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb.lap_count", int'(lap_count), e.cnt);
                        chk("sb.last", int'(last_sec) * 100 + int'(last_ms), e.lsec * 100 + e.lms);
                        chk("sb.best", int'(best_sec) * 100 + int'(best_ms), e.bsec * 100 + e.bms);
                        chk("sb.best_valid", int'(best_valid), e.bvalid);
                    end
                end
            end
            prev_rs = lap_rs;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, len, gap, sec, ms;
        repeat (3) @(posedge master_clk);
        #1;
        check_zero("in_reset");
        rs_n = 1'b1;
        repeat (4) @(posedge master_clk);
        #1;
        mon_en = 1;
        check_zero("post_reset");

        // Glitch, start, ignored break in lockout, then first lap 12.34
        do_break(3, 12, 0, 0, 0, 0);
        do_break(10, 8, 0, 0, 0, 0);
        do_break(4, 8, 5, 5, 0, 0);
        repeat (10) @(posedge master_clk);
        do_break(6, 20, 12, 34, 0, 0);
        chk("first_lap.last", int'(last_sec) * 100 + int'(last_ms), 1234);
        chk("first_lap.count", int'(lap_count), 1);

        // Best tracking with an equal time and a slower lap
        do_break(6, 20, 11, 50, 0, 0);
        do_break(6, 20, 11, 50, 0, 0);
        do_break(6, 20, 13, 0, 0, 0);
        chk("best_seq.best", int'(best_sec) * 100 + int'(best_ms), 1150);
        chk("best_seq.last", int'(last_sec) * 100 + int'(last_ms), 1300);
        chk("best_seq.count", int'(lap_count), 4);

        // Stop racing a break, clear in RUN, clear in IDLE, clear with start
        do_break(8, 20, 9, 9, 1, 0);
        chk("stop_race.count", int'(lap_count), 4);
        do_break(6, 20, 0, 0, 0, 0);
        pulse_ctl(0);
        pulse_ctl(1);
        pulse_ctl(0);
        chk("clear_idle.best_valid", int'(best_valid), 0);
        do_break(6, 20, 0, 0, 0, 0);
        do_break(6, 20, 30, 30, 0, 0);
        pulse_ctl(1);
        do_break(6, 20, 0, 0, 0, 1);

        // Random mix of breaks, glitches, stop/clear and idle gaps
        for (int n = 0; n < 150; n++) begin
            r   = int'($urandom_range(0, 99));
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3))
                                              : int'($urandom_range(4, 10));
            gap = int'($urandom_range(8, 24));
            sec = int'($urandom_range(0, 59));
            ms  = int'($urandom_range(0, 99));
            if (m_bvalid != 0 && $urandom_range(0, 3) == 0) begin
                sec = m_bsec;
                ms  = m_bms;
            end
            if (r < 55) do_break(len, gap, sec, ms, 0, 0);
            else if (r < 65) do_break(len, gap, sec, ms, running, 0);
            else if (r < 72) do_break(len, gap, sec, ms, 0, 1);
            else if (r < 80) pulse_ctl(1);
            else if (r < 88) pulse_ctl(0);
            else repeat ($urandom_range(1, 30)) @(posedge master_clk);
        end

        // Saturation at 99 laps
        pulse_ctl(1);
        pulse_ctl(0);
        do_break(5, 17, 0, 0, 0, 0);
        for (int n = 0; n < 101; n++) begin
            do_break(5, 17, int'($urandom_range(0, 59)), int'($urandom_range(0, 99)), 0, 0);
        end
        chk("saturate.count", int'(lap_count), 99);

        // Reset while locked out after a lap
        do_break(5, 8, 20, 20, 0, 0);
        do_reset();

        repeat (5) @(posedge master_clk);
        #1;
        chk("lap_rs_total", rs_seen, exp_rs);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lap_gate.md
LAP_GATE -- requirements
Module: lap_gate

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles needed before the filtered beam level changes.
REQ-002 Parameter LOCKOUT_CYCLES, default 4900000: cycles after a counted crossing during which further crossings are ignored.
REQ-003 Parameter LOCK_BIT, default 23: width of the lockout counter, LOCK_BIT bits, sized to hold LOCKOUT_CYCLES.
REQ-004 Port master_clk, input, 1: single clock; all state is rising-edge.
REQ-005 Port rs_n, input, 1: asynchronous active-low reset.
REQ-006 Port laser_detector, input, 1: raw asynchronous detector; 1 = beam received, 0 = beam broken.
REQ-007 Port stop, input, 1: synchronous level request to end the session.
REQ-008 Port clear, input, 1: synchronous level request to clear results; honoured in IDLE only.
REQ-009 Port seconds, input, 7: live timer seconds, 0-59.
REQ-010 Port milliseconds, input, 7: live timer hundredths, 0-99.
REQ-011 Port timer_en, output, 1: timer count enable.
REQ-012 Port lap_rs, output, 1: one-cycle timer reset pulse.
REQ-013 Port lap_pulse, output, 1: one-cycle pulse per counted lap.
REQ-014 Port lap_count, output, 7: counted laps, 0-99.
REQ-015 Port last_sec and last_ms, output, 7 each: latched time of the most recent lap.
REQ-016 Port best_sec, best_ms and best_valid, output, 7+7+1: fastest lap and its valid flag.

Function
REQ-017 laser_detector SHALL pass through a 2-flop synchronizer before any other use.
REQ-018 Debounce: the filtered level SHALL take the synchronized value once that value has differed from it for DEB_CYCLES consecutive cycles; any match restarts the count.
REQ-019 brk SHALL be a one-cycle internal strobe, asserted in the cycle the filtered level goes 1->0; 0->1 transitions produce nothing.
REQ-020 The FSM SHALL have three states, IDLE, RUN and LOCK; timer_en = 1 in RUN and LOCK, 0 in IDLE.
REQ-021 IDLE + brk -> LOCK: lap_rs = 1 for exactly the next cycle; lockout counter loads LOCKOUT_CYCLES-1; lap_count, last_* and best_* are unchanged.
REQ-022 LOCK SHALL decrement the counter each cycle, ignore brk, and go to RUN the cycle after the counter reads 0.
REQ-023 RUN + brk, on the next cycle: last_sec/last_ms latch seconds/milliseconds as sampled on the brk cycle; lap_pulse and lap_rs = 1 for one cycle; lap_count increments, saturating at 99; FSM -> LOCK with counter reloaded.
REQ-024 Best update: when best_valid = 0, or {sec,ms} < {best_sec,best_ms} (seconds most significant), best_* take the latched values and best_valid is set, on the same cycle as last_*.
REQ-025 An equal time SHALL NOT replace best.
REQ-026 stop in RUN or LOCK -> IDLE next cycle; timer_en drops; results hold; no lap is recorded.
REQ-027 stop and brk asserted on the same cycle: stop SHALL win and the lap SHALL NOT be recorded.
REQ-028 clear in IDLE zeroes lap_count, last_* and best_*, and clears best_valid, next cycle.
REQ-029 clear outside IDLE SHALL be ignored.
REQ-030 brk and clear together in IDLE: clear SHALL be applied and the session SHALL also start.
REQ-031 lap_rs and lap_pulse SHALL never be asserted for 2 consecutive cycles.
REQ-032 Every output SHALL be registered.

Reset
REQ-033 While rs_n = 0: FSM = IDLE, all outputs 0, synchronizer and filtered level = 1, debounce and lockout counters = 0.
REQ-034 Reset asserted mid-session SHALL abandon the session immediately, with no lap_rs or lap_pulse generated.
REQ-035 Release of rs_n SHALL be synchronized to master_clk inside the block.

Verification (DEB_CYCLES = 4, LOCKOUT_CYCLES = 20)
REQ-036 Glitch: laser_detector low for 3 cycles -> no brk, FSM stays IDLE, lap_rs never asserted.
REQ-037 Start: low for 10 cycles from IDLE -> one lap_rs pulse, timer_en = 1, lap_count = 0.
REQ-038 Lockout: second break 10 cycles after start -> ignored; break at 40 cycles with seconds = 12, ms = 34 -> last = 12.34, best = 12.34, best_valid = 1, lap_count = 1, lap_pulse = 1 for one cycle.
REQ-039 Best: laps 12.34, 11.50, 11.50, 13.00 -> best = 11.50, last = 13.00, lap_count = 4.
REQ-040 Stop/clear: stop coincident with brk -> IDLE, lap_count unchanged; clear in RUN -> no effect; clear in IDLE -> all results 0, best_valid = 0.
REQ-041 Saturation and reset: 101 counted laps -> lap_count = 99; rs_n pulsed low in LOCK -> every output 0 and FSM = IDLE.
